// File: rtl/msdap_serial_rx_if.sv
// Memory-write bus driven by the MSDAP serial front end toward the filter engines.
interface msdap_serial_rx_if #(
    parameter int unsigned NCH    = 2,
    parameter int unsigned WORD_W = 16,
    parameter int unsigned AW     = 9
);
    logic                    wr_rj;
    logic                    wr_coeff;
    logic                    wr_data;
    logic                    sample_valid;
    logic [AW-1:0]           wr_addr;
    logic [NCH*WORD_W-1:0]   wr_word;

    modport master (output wr_rj, wr_coeff, wr_data, sample_valid, wr_addr, wr_word);
    modport slave  (input  wr_rj, wr_coeff, wr_data, sample_valid, wr_addr, wr_word);
endinterface

// File: rtl/msdap_serial_rx.sv
// MSDAP serial front end: oversampled deserialiser, configuration-phase word routing,
// data-buffer flush and zero-run sleep/wake control.
module msdap_serial_rx #(
    parameter int unsigned NCH         = 2,
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned RJ_DEPTH    = 16,
    parameter int unsigned COEFF_DEPTH = 512,
    parameter int unsigned DATA_DEPTH  = 256,
    parameter int unsigned SLEEP_CNT   = 800,
    parameter int unsigned AW          = $clog2(COEFF_DEPTH)
) (
    input  logic            sClk,
    input  logic            reset_n,
    input  logic            dClk,
    input  logic            frame,
    input  logic [NCH-1:0]  sdata,
    input  logic            start,
    input  logic            clear,
    output logic            in_ready,
    output logic            sleep,
    output logic            flushing,
    msdap_serial_rx_if.master wr
);
    localparam int unsigned WW = NCH * WORD_W;
    localparam int unsigned BW = $clog2(WORD_W + 1);
    localparam int unsigned ZW = $clog2(SLEEP_CNT + 1);

    typedef enum logic [2:0] {IDLE, FLUSH, RJ, COEFF, WORK, SLEEP} state_t;

    state_t                          state;
    logic                            retWork;
    logic [AW-1:0]                   wordIdx;
    logic [AW-1:0]                   dataPtr;
    logic [AW-1:0]                   flushCnt;
    logic [ZW-1:0]                   zeroCnt;

    logic                            dClkMeta, dClkSync, dClkPrev, bitStrobe;
    logic                            frameMeta, frameSync, frameBit;
    logic [NCH-1:0]                  sdataMeta, sdataSync, sdataBit;

    logic [NCH-1:0][WORD_W-1:0]      shiftReg, shiftNext;
    logic [BW-1:0]                   bitCnt, cntNext;
    logic                            bitActive_c, wordDone_c, allZero_c, flushDone_c;
    logic [WW-1:0]                   wordNext;

    // Two-flop synchroniser plus edge register; strobe marks a dClk falling edge.
    always_ff @(posedge sClk or negedge reset_n) begin
        if (!reset_n) begin
            dClkMeta  <= 1'b0;
            dClkSync  <= 1'b0;
            dClkPrev  <= 1'b0;
            bitStrobe <= 1'b0;
            frameMeta <= 1'b0;
            frameSync <= 1'b0;
            frameBit  <= 1'b0;
            sdataMeta <= '0;
            sdataSync <= '0;
            sdataBit  <= '0;
        end else begin
            dClkMeta  <= dClk;
            dClkSync  <= dClkMeta;
            dClkPrev  <= dClkSync;
            bitStrobe <= dClkPrev & ~dClkSync;
            frameMeta <= frame;
            frameSync <= frameMeta;
            frameBit  <= frameSync;
            sdataMeta <= sdata;
            sdataSync <= sdataMeta;
            sdataBit  <= sdataSync;
        end
    end

    // Next deserialiser contents; frame restarts the word at bit 1, aborting any partial word.
    always_comb begin
        shiftNext = shiftReg;
        cntNext   = frameBit ? BW'(1) : bitCnt + BW'(1);
        for (int c = 0; c < NCH; c++) begin
            if (frameBit) shiftNext[c] = {{(WORD_W-1){1'b0}}, sdataBit[c]};
            else          shiftNext[c] = {shiftReg[c][WORD_W-2:0], sdataBit[c]};
        end
        bitActive_c = bitStrobe && (frameBit || (bitCnt != '0));
        wordDone_c  = bitActive_c && (cntNext == BW'(WORD_W));
        wordNext    = shiftNext;
        allZero_c   = (wordNext == '0);
        flushDone_c = (state == FLUSH) && (flushCnt == AW'(DATA_DEPTH - 1));
    end

    always_ff @(posedge sClk or negedge reset_n) begin
        if (!reset_n) begin
            shiftReg <= '0;
            bitCnt   <= '0;
        end else if (flushDone_c) begin
            shiftReg <= '0;
            bitCnt   <= '0;
        end else if (bitActive_c) begin
            shiftReg <= shiftNext;
            bitCnt   <= wordDone_c ? '0 : cntNext;
        end
    end

    // Control FSM with registered write bus and status outputs.
    always_ff @(posedge sClk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            retWork         <= 1'b0;
            wordIdx         <= '0;
            dataPtr         <= '0;
            flushCnt        <= '0;
            zeroCnt         <= '0;
            in_ready        <= 1'b0;
            sleep           <= 1'b0;
            flushing        <= 1'b0;
            wr.wr_rj        <= 1'b0;
            wr.wr_coeff     <= 1'b0;
            wr.wr_data      <= 1'b0;
            wr.sample_valid <= 1'b0;
            wr.wr_addr      <= '0;
            wr.wr_word      <= '0;
        end else begin
            wr.wr_rj        <= 1'b0;
            wr.wr_coeff     <= 1'b0;
            wr.wr_data      <= 1'b0;
            wr.sample_valid <= 1'b0;
            wr.wr_addr      <= '0;
            wr.wr_word      <= '0;
            flushing        <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FLUSH;
                        retWork  <= 1'b0;
                        flushCnt <= '0;
                    end
                end
                FLUSH: begin
                    wr.wr_data <= 1'b1;
                    wr.wr_addr <= flushCnt;
                    flushing   <= 1'b1;
                    flushCnt   <= flushCnt + AW'(1);
                    if (flushDone_c) begin
                        state    <= retWork ? WORK : RJ;
                        dataPtr  <= '0;
                        zeroCnt  <= '0;
                        wordIdx  <= '0;
                        in_ready <= 1'b1;
                    end
                end
                RJ: begin
                    if (wordDone_c) begin
                        wr.wr_rj   <= 1'b1;
                        wr.wr_addr <= wordIdx;
                        wr.wr_word <= wordNext;
                        if (wordIdx == AW'(RJ_DEPTH - 1)) begin
                            wordIdx <= '0;
                            state   <= COEFF;
                        end else begin
                            wordIdx <= wordIdx + AW'(1);
                        end
                    end
                end
                COEFF: begin
                    if (wordDone_c) begin
                        wr.wr_coeff <= 1'b1;
                        wr.wr_addr  <= wordIdx;
                        wr.wr_word  <= wordNext;
                        if (wordIdx == AW'(COEFF_DEPTH - 1)) begin
                            wordIdx <= '0;
                            state   <= WORK;
                        end else begin
                            wordIdx <= wordIdx + AW'(1);
                        end
                    end
                end
                WORK, SLEEP: begin
                    if (clear) begin
                        // A word completing alongside clear is dropped.
                        state    <= FLUSH;
                        retWork  <= 1'b1;
                        flushCnt <= '0;
                        in_ready <= 1'b0;
                        sleep    <= 1'b0;
                    end else if (wordDone_c && (state == WORK || !allZero_c)) begin
                        wr.wr_data      <= 1'b1;
                        wr.sample_valid <= 1'b1;
                        wr.wr_addr      <= dataPtr;
                        wr.wr_word      <= wordNext;
                        dataPtr <= (dataPtr == AW'(DATA_DEPTH - 1)) ? '0 : dataPtr + AW'(1);
                        if (state == SLEEP) begin
                            state <= WORK;
                            sleep <= 1'b0;
                        end else if (!allZero_c) begin
                            zeroCnt <= '0;
                        end else if (zeroCnt == ZW'(SLEEP_CNT - 1)) begin
                            state   <= SLEEP;
                            sleep   <= 1'b1;
                            zeroCnt <= '0;
                        end else begin
                            zeroCnt <= zeroCnt + ZW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_msdap_serial_rx.sv
// Directed bench for msdap_serial_rx: serial word driver, queue-based write model,
// per-cycle write comparison and literal anchor checks.
module tb_msdap_serial_rx;
    localparam int unsigned NCH         = 2;
    localparam int unsigned WORD_W      = 16;
    localparam int unsigned RJ_DEPTH    = 16;
    localparam int unsigned COEFF_DEPTH = 32;
    localparam int unsigned DATA_DEPTH  = 32;
    localparam int unsigned SLEEP_CNT   = 20;
    localparam int unsigned AW          = $clog2(COEFF_DEPTH);
    localparam int unsigned WW          = NCH * WORD_W;

    logic           sClk = 1'b0;
    logic           reset_n = 1'b0;
    logic           dClk = 1'b0;
    logic           frame = 1'b0;
    logic [NCH-1:0] sdata = '0;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic           in_ready, sleep, flushing;

    msdap_serial_rx_if #(.NCH(NCH), .WORD_W(WORD_W), .AW(AW)) wrIf ();

    msdap_serial_rx #(
        .NCH(NCH), .WORD_W(WORD_W), .RJ_DEPTH(RJ_DEPTH), .COEFF_DEPTH(COEFF_DEPTH),
        .DATA_DEPTH(DATA_DEPTH), .SLEEP_CNT(SLEEP_CNT), .AW(AW)
    ) dut (
        .sClk(sClk), .reset_n(reset_n), .dClk(dClk), .frame(frame), .sdata(sdata),
        .start(start), .clear(clear), .in_ready(in_ready), .sleep(sleep),
        .flushing(flushing), .wr(wrIf)
    );

    always #5 sClk = ~sClk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: 1=rj 2=coeff 3=data sample 4=flush write
    typedef struct {
        int          kind;
        int          addr;
        logic [WW-1:0] word;
        bit          sv;
        bit          slp;
    } exp_t;

    exp_t q[$];
    int   mPhase = 0;   // 1 rj, 2 coeff, 3 work, 4 sleep
    int   mIdx = 0, mPtr = 0, mZeros = 0;

    function automatic void modelWord(input logic [WW-1:0] w);
        exp_t e;
        case (mPhase)
            1, 2: begin
                e = '{mPhase, mIdx, w, 1'b0, 1'b0};
                q.push_back(e);
                mIdx++;
                if (mPhase == 1 && mIdx == RJ_DEPTH)         begin mPhase = 2; mIdx = 0; end
                else if (mPhase == 2 && mIdx == COEFF_DEPTH) begin mPhase = 3; mIdx = 0; end
            end
            3: begin
                mZeros = (w == '0) ? mZeros + 1 : 0;
                e = '{3, mPtr, w, 1'b1, (mZeros == SLEEP_CNT)};
                q.push_back(e);
                mPtr = (mPtr + 1) % DATA_DEPTH;
                if (mZeros == SLEEP_CNT) begin mPhase = 4; mZeros = 0; end
            end
            4: begin
                if (w != '0) begin
                    e = '{3, mPtr, w, 1'b1, 1'b0};
                    q.push_back(e);
                    mPtr = (mPtr + 1) % DATA_DEPTH;
                    mPhase = 3;
                end
            end
            default: ;
        endcase
    endfunction

    function automatic void modelFlush();
        exp_t e;
        for (int a = 0; a < DATA_DEPTH; a++) begin
            e = '{4, a, '0, 1'b0, 1'b0};
            q.push_back(e);
        end
        mPtr = 0;
        mZeros = 0;
        if (mPhase == 4) mPhase = 3;
    endfunction

    // Compare process: every write-bus event is matched against the model queue.
    int nRj = 0, nCoeff = 0, nData = 0, nSv = 0, flushCycles = 0;
    int cmpN, cmpK, lastKind = 0, lastAddr = -1;
    logic [WW-1:0] lastWord = '0;
    exp_t cur;

    always @(negedge sClk) begin
        if (reset_n) begin
            cmpN = int'(wrIf.wr_rj) + int'(wrIf.wr_coeff) + int'(wrIf.wr_data);
            if (cmpN > 1) check("strobe_onehot", cmpN, 1);
            if (cmpN != 0 || wrIf.sample_valid) begin
                cmpK = wrIf.wr_rj ? 1 : wrIf.wr_coeff ? 2 : wrIf.wr_data ? (flushing ? 4 : 3) : 0;
                check("write_expected", longint'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    cur = q.pop_front();
                    check("wr_kind", cmpK, cur.kind);
                    check("wr_addr", longint'(wrIf.wr_addr), cur.addr);
                    check("wr_word", longint'(wrIf.wr_word), longint'(cur.word));
                    check("sample_valid", longint'(wrIf.sample_valid), longint'(cur.sv));
                    check("sleep_at_write", longint'(sleep), longint'(cur.slp));
                end
                nRj    += int'(wrIf.wr_rj);
                nCoeff += int'(wrIf.wr_coeff);
                nData  += int'(wrIf.wr_data);
                nSv    += int'(wrIf.sample_valid);
                lastKind = cmpK;
                lastAddr = int'(wrIf.wr_addr);
                lastWord = wrIf.wr_word;
            end
            if (flushing) flushCycles++;
        end
    end

    task automatic sendBits(input logic [WW-1:0] w, input int nbits);
        for (int b = 0; b < nbits; b++) begin
            @(posedge sClk); #1;
            dClk  = 1'b1;
            frame = (b == 0);
            for (int c = 0; c < NCH; c++) sdata[c] = w[c*WORD_W + WORD_W - 1 - b];
            repeat (8) @(posedge sClk);
            #1 dClk = 1'b0;
            repeat (8) @(posedge sClk);
        end
        frame = 1'b0;
    endtask

    task automatic sendWord(input logic [WW-1:0] w);
        modelWord(w);
        sendBits(w, WORD_W);
    endtask

    task automatic pulse(input int which);
        @(posedge sClk); #1;
        if (which == 0) start = 1'b1; else clear = 1'b1;
        @(posedge sClk); #1;
        start = 1'b0;
        clear = 1'b0;
    endtask

    task automatic waitReady(input string nm);
        for (int i = 0; i < 4 * DATA_DEPTH && !in_ready; i++) @(posedge sClk);
        @(negedge sClk);
        check(nm, longint'(in_ready), 1);
    endtask

    int snap, snapData;
    logic [WW-1:0] w;

    initial begin
        // Reset state
        repeat (3) @(negedge sClk);
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_sleep", longint'(sleep), 0);
        check("rst_flushing", longint'(flushing), 0);
        check("rst_strobes", longint'({wrIf.wr_rj, wrIf.wr_coeff, wrIf.wr_data, wrIf.sample_valid}), 0);
        check("rst_addr_word", longint'({wrIf.wr_addr, wrIf.wr_word}), 0);
        #1 reset_n = 1'b1;
        repeat (3) @(posedge sClk);

        // Start -> initial flush -> RJ
        mPhase = 1;
        modelFlush();
        snap = flushCycles;
        pulse(0);
        waitReady("ready_after_start");
        check("flush_cycles_start", flushCycles - snap, DATA_DEPTH);
        check("flush_writes_start", nData, DATA_DEPTH);

        // Rj load, first coefficient pinned
        for (int i = 0; i < RJ_DEPTH; i++) begin
            w = {16'(16'h0020 + i), 16'(16'h0010 + i)};
            sendWord(w);
            if (i == 0) check("rj0_word_literal", longint'(lastWord), 64'h0020_0010);
        end
        check("rj_count", nRj, RJ_DEPTH);
        sendWord({16'hC0DE, 16'h0C0E});
        check("coeff0_kind_literal", lastKind, 2);
        check("coeff0_addr_literal", lastAddr, 0);
        for (int i = 1; i < COEFF_DEPTH; i++) sendWord({16'(16'h4000 + i), 16'(16'h3000 + i)});
        check("coeff_count", nCoeff, COEFF_DEPTH);

        // Data stream with pointer wrap
        for (int i = 1; i <= 40; i++) begin
            sendWord({16'hABCD, 16'h1234});
            if (i == DATA_DEPTH)     check("ptr_before_wrap", lastAddr, DATA_DEPTH - 1);
            if (i == DATA_DEPTH + 1) check("ptr_after_wrap", lastAddr, 0);
        end
        check("sv_count_data", nSv, 40);

        // Zero run into sleep, dropped zeros, wake
        for (int i = 1; i <= SLEEP_CNT; i++) begin
            sendWord('0);
            if (i == SLEEP_CNT - 1) check("sleep_before_last_zero", longint'(sleep), 0);
        end
        check("sleep_entered", longint'(sleep), 1);
        snapData = nData;
        for (int i = 0; i < 10; i++) sendWord('0);
        check("sleep_zero_drop", nData - snapData, 0);
        sendWord({16'h0000, 16'h0001});
        check("wake_addr_literal", lastAddr, 28);
        check("wake_sleep_low", longint'(sleep), 0);

        // Clear in WORK with pointer at 37 mod depth
        for (int i = 0; i < 8; i++) sendWord({16'(16'h0100 + i), 16'h5555});
        check("ptr_before_clear", lastAddr, 4);
        modelFlush();
        snap = flushCycles;
        snapData = nSv;
        pulse(1);
        waitReady("ready_after_clear");
        check("flush_cycles_clear", flushCycles - snap, DATA_DEPTH);
        check("no_sv_in_flush", nSv - snapData, 0);
        sendWord({16'h7777, 16'h6666});
        check("addr_after_clear_literal", lastAddr, 0);
        check("rj_untouched", nRj, RJ_DEPTH);
        check("coeff_untouched", nCoeff, COEFF_DEPTH);

        // Frame re-asserted after 7 bits
        sendBits({16'hFFFF, 16'hFFFF}, 7);
        sendWord({16'h8001, 16'h8001});
        check("restart_word_literal", longint'(lastWord), 64'h8001_8001);
        check("restart_addr_literal", lastAddr, 1);

        repeat (10) @(posedge sClk);
        check("model_queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
